// File: rtl/uart_rx_frame_if.sv
// Serial-line inputs and per-frame result signals of the UART byte assembler.
// slave is the receiver's view; master is the upstream/downstream view.
interface uart_rx_frame_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx_in;
  logic                 start_edge;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 parity_err;
  logic                 busy;

  modport master (
    output rx_in, start_edge,
    input  rx_data, rx_valid, frame_err, parity_err, busy
  );

  modport slave (
    input  rx_in, start_edge,
    output rx_data, rx_valid, frame_err, parity_err, busy
  );
endinterface

// File: rtl/uart_rx_frame.sv
// UART byte assembler (8N1, or 8E1 when RX_PARITY_EN is defined); result strobe HALF+(DATA_BITS+1)*CLKS_PER_BIT+1
// cycles after start_edge (+CLKS_PER_BIT with parity); no backpressure, every strobe is a single registered cycle.
module uart_rx_frame #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_rx_frame_if.slave bus
);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int TW   = $clog2(CLKS_PER_BIT);
  localparam int CW   = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state, state_nxt;
  logic [TW-1:0]        timer;
  logic [CW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift_q, data_q;
  logic                 sync1, rx_s;
  logic                 valid_q, ferr_q;
  logic                 valid_nxt, ferr_nxt;
  logic                 half_done, bit_done, last_bit;

`ifdef RX_PARITY_EN
  logic par_acc, par_bad_q, perr_q, perr_nxt;
`endif

  assign half_done = (timer == TW'(HALF - 1));
  assign bit_done  = (timer == TW'(CLKS_PER_BIT - 1));
  assign last_bit  = (bit_cnt == CW'(DATA_BITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= bus.rx_in;
      rx_s  <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (bus.start_edge) state_nxt = START;
      START:  if (half_done) state_nxt = rx_s ? IDLE : DATA;
      DATA: begin
        if (bit_done && last_bit) begin
`ifdef RX_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
        end
      end
      PARITY: if (bit_done) state_nxt = STOP;
      STOP:   if (bit_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A low stop bit outranks a parity mismatch.
  always_comb begin
    valid_nxt = 1'b0;
    ferr_nxt  = 1'b0;
`ifdef RX_PARITY_EN
    perr_nxt  = 1'b0;
`endif
    if (state == STOP && bit_done) begin
      if (!rx_s) ferr_nxt = 1'b1;
`ifdef RX_PARITY_EN
      else if (par_bad_q) perr_nxt = 1'b1;
`endif
      else valid_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer   <= '0;
      bit_cnt <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      if (state == IDLE || state_nxt != state) timer <= '0;
      else                                     timer <= timer + 1'b1;

      if (state != DATA)  bit_cnt <= '0;
      else if (bit_done)  bit_cnt <= bit_cnt + 1'b1;

      if (state == DATA && bit_done) shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};

      valid_q <= valid_nxt;
      ferr_q  <= ferr_nxt;
      if (valid_nxt) data_q <= shift_q;
    end
  end

`ifdef RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_acc   <= 1'b0;
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      if (state == START) begin
        par_acc   <= 1'b0;
        par_bad_q <= 1'b0;
      end else if (state == DATA && bit_done) begin
        par_acc <= par_acc ^ rx_s;
      end else if (state == PARITY && bit_done) begin
        par_bad_q <= par_acc ^ rx_s;
      end
      perr_q <= perr_nxt;
    end
  end
  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.rx_data   = data_q;
  assign bus.rx_valid  = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: good frames, back-to-back, false start, framing error, mid-frame reset, parity.
// Strobes are collected on the falling edge; stimulus is driven 1 time unit after each rising edge.
module tb_uart_rx_frame;
  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
`ifdef RX_PARITY_EN
  localparam int LAT   = HALF + 10 * CPB + 1;
  localparam int FRAME = 11 * CPB;
`else
  localparam int LAT   = HALF + 9 * CPB + 1;
  localparam int FRAME = 10 * CPB;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   valid_cnt = 0, ferr_cnt = 0, perr_cnt = 0;
  int   valid_cyc[$];
  logic [7:0] valid_dat[$];
  int   start_cyc;

  uart_rx_frame_if #(.DATA_BITS(8)) bus ();

  uart_rx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.rx_valid) begin
      valid_cnt++;
      valid_cyc.push_back(cyc);
      valid_dat.push_back(bus.rx_data);
    end
    if (bus.frame_err)  ferr_cnt++;
    if (bus.parity_err) perr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one whole frame; start_edge accompanies the falling edge of the start bit.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
    start_cyc      = cyc;
    bus.rx_in      = 1'b0;
    bus.start_edge = 1'b1;
    tick(1);
    bus.start_edge = 1'b0;
    tick(CPB - 1);
    for (int i = 0; i < 8; i++) begin
      bus.rx_in = d[i];
      tick(CPB);
    end
`ifdef RX_PARITY_EN
    bus.rx_in = par_b;
    tick(CPB);
`else
    if (par_b) begin end
`endif
    bus.rx_in = stop_b;
    tick(CPB);
    bus.rx_in = 1'b1;
  endtask

  initial begin
    int v0, f0, p0, q0, s0;
    logic [7:0] b;

    rst_n          = 1'b0;
    bus.rx_in      = 1'b1;
    bus.start_edge = 1'b0;
    tick(3);
    check("rst_data",  bus.rx_data, 8'h00);
    check("rst_valid", bus.rx_valid, 1'b0);
    check("rst_ferr",  bus.frame_err, 1'b0);
    check("rst_perr",  bus.parity_err, 1'b0);
    check("rst_busy",  bus.busy, 1'b0);
    rst_n = 1'b1;
    tick(4);

    // Single good frame.
    v0 = valid_cnt; f0 = ferr_cnt;
    b = 8'hA5;
    send_frame(b, 1'b1, ^b);
    tick(4);
    check("a5_cnt",  valid_cnt - v0, 1);
    check("a5_lat",  valid_cyc[valid_cyc.size()-1] - start_cyc, LAT);
    check("a5_data", bus.rx_data, 8'hA5);
    check("a5_ferr", ferr_cnt - f0, 0);

    // Back-to-back frames with no idle gap.
    v0 = valid_cnt; q0 = valid_cyc.size();
    b = 8'h00;
    send_frame(b, 1'b1, ^b);
    s0 = start_cyc;
    b = 8'hFF;
    send_frame(b, 1'b1, ^b);
    tick(4);
    check("b2b_cnt",   valid_cnt - v0, 2);
    check("b2b_lat",   valid_cyc[q0] - s0, LAT);
    check("b2b_gap",   valid_cyc[q0+1] - valid_cyc[q0], FRAME);
    check("b2b_dat0",  valid_dat[q0], 8'h00);
    check("b2b_dat1",  valid_dat[q0+1], 8'hFF);

    // False start: three-cycle low glitch.
    v0 = valid_cnt; f0 = ferr_cnt; p0 = perr_cnt;
    bus.rx_in      = 1'b0;
    bus.start_edge = 1'b1;
    tick(1);
    bus.start_edge = 1'b0;
    tick(2);
    bus.rx_in = 1'b1;
    check("glitch_busy_early", bus.busy, 1'b1);
    tick(5);
    check("glitch_busy_c8", bus.busy, 1'b1);
    tick(1);
    check("glitch_busy_c9", bus.busy, 1'b0);
    tick(CPB * 2);
    check("glitch_strobes", (valid_cnt - v0) + (ferr_cnt - f0) + (perr_cnt - p0), 0);

    // Framing error: stop bit low.
    v0 = valid_cnt; f0 = ferr_cnt;
    b = 8'h3C;
    send_frame(b, 1'b0, ^b);
    tick(CPB);
    check("ferr_cnt",   ferr_cnt - f0, 1);
    check("ferr_valid", valid_cnt - v0, 0);
    check("ferr_data",  bus.rx_data, 8'hFF);

    // Reset in the middle of data bit 4, then a clean frame.
    v0 = valid_cnt; f0 = ferr_cnt; p0 = perr_cnt;
    b = 8'hC3;
    bus.rx_in      = 1'b0;
    bus.start_edge = 1'b1;
    tick(1);
    bus.start_edge = 1'b0;
    tick(CPB - 1);
    for (int i = 0; i < 4; i++) begin
      bus.rx_in = b[i];
      tick(CPB);
    end
    bus.rx_in = b[4];
    tick(HALF);
    check("abort_busy_pre", bus.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("abort_busy_rst", bus.busy, 1'b0);
    check("abort_data_rst", bus.rx_data, 8'h00);
    tick(3);
    rst_n     = 1'b1;
    bus.rx_in = 1'b1;
    tick(CPB * 10);
    check("abort_strobes", (valid_cnt - v0) + (ferr_cnt - f0) + (perr_cnt - p0), 0);
    b = 8'h5A;
    send_frame(b, 1'b1, ^b);
    tick(4);
    check("post_rst_cnt",  valid_cnt - v0, 1);
    check("post_rst_data", bus.rx_data, 8'h5A);

`ifdef RX_PARITY_EN
    // 0x07 has three ones, so even parity needs a 1.
    v0 = valid_cnt; p0 = perr_cnt;
    send_frame(8'h07, 1'b1, 1'b0);
    tick(4);
    check("par_bad_perr",  perr_cnt - p0, 1);
    check("par_bad_valid", valid_cnt - v0, 0);
    check("par_bad_data",  bus.rx_data, 8'h5A);
    v0 = valid_cnt; p0 = perr_cnt;
    send_frame(8'h07, 1'b1, 1'b1);
    tick(4);
    check("par_ok_perr",  perr_cnt - p0, 0);
    check("par_ok_valid", valid_cnt - v0, 1);
    check("par_ok_data",  bus.rx_data, 8'h07);
`else
    check("no_parity_err", perr_cnt, 0);
`endif

    check("final_busy", bus.busy, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
